// File: rtl/obi_mem_arbiter_pkg.sv
// Shared definitions for the OBI instruction/data memory arbiter.
// Holds the requester encoding, the arbitration state encoding and response FIFO entry helpers.
package obi_mem_arbiter_pkg;

    typedef enum logic {
        OWNER_IMEM = 1'b0,
        OWNER_DMEM = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Each response FIFO entry is {owner, addr[2]}.
    localparam int unsigned RESP_ENTRY_W = 2;
    localparam logic [7:0]  IMEM_BE      = 8'hFF;

    function automatic logic [RESP_ENTRY_W-1:0] resp_entry(input owner_e owner, input logic addr2);
        return {owner, addr2};
    endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order FIFO of outstanding transactions awaiting a response.
// A push is accepted while full only if an entry pops in the same cycle.
module obi_resp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = storage[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Arbitrates an instruction-fetch and a data OBI port onto one shared memory port,
// with starvation protection for fetch and in-order response routing.
module obi_mem_arbiter
    import obi_mem_arbiter_pkg::*;
#(
    parameter int unsigned VADDR      = 39,
    parameter int unsigned MAX_OUTST  = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             imem_req_i,
    input  logic [VADDR-1:0] imem_addr_i,
    output logic             imem_gnt_o,
    output logic             imem_rvalid_o,
    output logic [31:0]      imem_rdata_o,
    input  logic             dmem_req_i,
    input  logic             dmem_we_i,
    input  logic [7:0]       dmem_be_i,
    input  logic [VADDR-1:0] dmem_addr_i,
    input  logic [63:0]      dmem_wdata_i,
    output logic             dmem_gnt_o,
    output logic             dmem_rvalid_o,
    output logic [63:0]      dmem_rdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [7:0]       mem_be_o,
    output logic [VADDR-1:0] mem_addr_o,
    output logic [63:0]      mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [63:0]      mem_rdata_i,
    output logic             busy_o
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIM + 1);

    arb_state_e                 state;
    owner_e                     lock_owner;
    logic                       lock_we;
    logic [7:0]                 lock_be;
    logic [VADDR-1:0]           lock_addr;
    logic [63:0]                lock_wdata;
    logic [STARVE_W-1:0]        starve_cnt;

    owner_e                     owner;
    logic                       want;
    logic                       grant;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_pop;
    logic [RESP_ENTRY_W-1:0]    fifo_head;
    owner_e                     head_owner;

    // Fresh arbitration in IDLE; while LOCKED the captured request is replayed unchanged.
    always_comb begin
        owner       = OWNER_IMEM;
        want        = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = IMEM_BE;
        mem_addr_o  = imem_addr_i;
        mem_wdata_o = '0;
        if (state == ST_LOCKED) begin
            owner       = lock_owner;
            want        = 1'b1;
            mem_we_o    = lock_we;
            mem_be_o    = lock_be;
            mem_addr_o  = lock_addr;
            mem_wdata_o = lock_wdata;
        end else if (dmem_req_i && (!imem_req_i || starve_cnt < STARVE_W'(STARVE_LIM))) begin
            owner       = OWNER_DMEM;
            want        = 1'b1;
            mem_we_o    = dmem_we_i;
            mem_be_o    = dmem_be_i;
            mem_addr_o  = dmem_addr_i;
            mem_wdata_o = dmem_wdata_i;
        end else if (imem_req_i) begin
            want        = 1'b1;
        end
    end

    assign fifo_pop   = mem_rvalid_i && !fifo_empty;
    assign mem_req_o  = want && !rst_i && (!fifo_full || fifo_pop);
    assign grant      = mem_req_o && mem_gnt_i;
    assign imem_gnt_o = grant && (owner == OWNER_IMEM);
    assign dmem_gnt_o = grant && (owner == OWNER_DMEM);

    assign head_owner    = owner_e'(fifo_head[1]);
    assign imem_rvalid_o = fifo_pop && (head_owner == OWNER_IMEM);
    assign dmem_rvalid_o = fifo_pop && (head_owner == OWNER_DMEM);
    assign imem_rdata_o  = fifo_head[0] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    assign dmem_rdata_o  = mem_rdata_i;
    assign busy_o        = !fifo_empty || (state == ST_LOCKED);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            lock_owner <= OWNER_IMEM;
            lock_we    <= 1'b0;
            lock_be    <= '0;
            lock_addr  <= '0;
            lock_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state      <= ST_LOCKED;
                        lock_owner <= owner;
                        lock_we    <= mem_we_o;
                        lock_be    <= mem_be_o;
                        lock_addr  <= mem_addr_o;
                        lock_wdata <= mem_wdata_o;
                    end
                end
                ST_LOCKED: begin
                    if (grant) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Counts dmem wins over a waiting imem; saturates so imem wins the next arbitration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (owner == OWNER_IMEM) begin
                starve_cnt <= '0;
            end else if (imem_req_i && starve_cnt < STARVE_W'(STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    obi_resp_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (RESP_ENTRY_W)
    ) u_resp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (grant),
        .push_data (resp_entry(owner, mem_addr_o[2])),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_obi_mem_arbiter;

    localparam int VADDR      = 39;
    localparam int MAX_OUTST  = 2;
    localparam int STARVE_LIM = 4;

    typedef struct packed {
        logic             rst;
        logic             imem_req;
        logic [VADDR-1:0] imem_addr;
        logic             dmem_req;
        logic             dmem_we;
        logic [7:0]       dmem_be;
        logic [VADDR-1:0] dmem_addr;
        logic [63:0]      dmem_wdata;
        logic             gnt;
        logic             rvalid;
        logic [63:0]      rdata;
    } stim_t;

    typedef struct packed {
        bit is_dmem;
        bit a2;
    } entry_t;

    logic             clk;
    logic             rst;
    logic             imem_req, imem_gnt, imem_rvalid;
    logic [VADDR-1:0] imem_addr;
    logic [31:0]      imem_rdata;
    logic             dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [7:0]       dmem_be;
    logic [VADDR-1:0] dmem_addr;
    logic [63:0]      dmem_wdata, dmem_rdata;
    logic             mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [7:0]       mem_be;
    logic [VADDR-1:0] mem_addr;
    logic [63:0]      mem_wdata, mem_rdata;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: outstanding queue, starvation tally and a captured locked request.
    entry_t           outst[$];
    int               starve;
    bit               locked;
    bit               lk_dmem;
    logic [VADDR-1:0] lk_addr;
    logic             lk_we;
    logic [7:0]       lk_be;
    logic [63:0]      lk_wdata;

    stim_t s;

    obi_mem_arbiter #(
        .VADDR      (VADDR),
        .MAX_OUTST  (MAX_OUTST),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_i    (imem_req),
        .imem_addr_i   (imem_addr),
        .imem_gnt_o    (imem_gnt),
        .imem_rvalid_o (imem_rvalid),
        .imem_rdata_o  (imem_rdata),
        .dmem_req_i    (dmem_req),
        .dmem_we_i     (dmem_we),
        .dmem_be_i     (dmem_be),
        .dmem_addr_i   (dmem_addr),
        .dmem_wdata_i  (dmem_wdata),
        .dmem_gnt_o    (dmem_gnt),
        .dmem_rvalid_o (dmem_rvalid),
        .dmem_rdata_o  (dmem_rdata),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_be_o      (mem_be),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input stim_t st);
        rst        = st.rst;
        imem_req   = st.imem_req;
        imem_addr  = st.imem_addr;
        dmem_req   = st.dmem_req;
        dmem_we    = st.dmem_we;
        dmem_be    = st.dmem_be;
        dmem_addr  = st.dmem_addr;
        dmem_wdata = st.dmem_wdata;
        mem_gnt    = st.gnt;
        mem_rvalid = st.rvalid;
        mem_rdata  = st.rdata;
    endtask

    // Predicts this cycle's outputs from the rules, compares, then advances the model past the next edge.
    task automatic modelStep();
        bit               e_valid, e_dmem, e_req, e_grant, pop;
        logic [VADDR-1:0] e_addr;
        logic             e_we;
        logic [7:0]       e_be;
        logic [63:0]      e_wdata;
        bit               h_dmem, h_a2;
        if (rst) begin
            outst.delete();
            starve = 0;
            locked = 0;
        end
        if (locked) begin
            e_valid = 1; e_dmem = lk_dmem; e_addr = lk_addr;
            e_we = lk_we; e_be = lk_be; e_wdata = lk_wdata;
        end else begin
            e_dmem  = dmem_req && (!imem_req || starve < STARVE_LIM);
            e_valid = e_dmem || imem_req;
            if (e_dmem) begin
                e_addr = dmem_addr; e_we = dmem_we; e_be = dmem_be; e_wdata = dmem_wdata;
            end else begin
                e_addr = imem_addr; e_we = 0; e_be = 8'hFF; e_wdata = '0;
            end
        end
        pop     = mem_rvalid && (outst.size() != 0);
        e_req   = e_valid && !rst && ((outst.size() < MAX_OUTST) || pop);
        e_grant = e_req && mem_gnt;
        h_dmem  = (outst.size() != 0) ? outst[0].is_dmem : 1'b0;
        h_a2    = (outst.size() != 0) ? outst[0].a2 : 1'b0;

        checkOutput("mem_req", mem_req, e_req);
        if (e_req) begin
            checkOutput("mem_addr", mem_addr, e_addr);
            checkOutput("mem_we", mem_we, e_we);
            checkOutput("mem_be", mem_be, e_be);
            checkOutput("mem_wdata", mem_wdata, e_wdata);
        end
        checkOutput("imem_gnt", imem_gnt, e_grant && !e_dmem);
        checkOutput("dmem_gnt", dmem_gnt, e_grant && e_dmem);
        checkOutput("imem_rvalid", imem_rvalid, pop && !h_dmem);
        checkOutput("dmem_rvalid", dmem_rvalid, pop && h_dmem);
        if (pop && !h_dmem) checkOutput("imem_rdata", imem_rdata, h_a2 ? mem_rdata[63:32] : mem_rdata[31:0]);
        if (pop && h_dmem)  checkOutput("dmem_rdata", dmem_rdata, mem_rdata);
        checkOutput("busy", busy, (outst.size() != 0) || locked);

        if (!rst) begin
            if (pop) void'(outst.pop_front());
            if (e_grant) outst.push_back(entry_t'{e_dmem, e_addr[2]});
            if (e_grant && !e_dmem) starve = 0;
            else if (e_grant && imem_req && starve < STARVE_LIM) starve++;
            if (!locked && e_req && !mem_gnt) begin
                locked = 1; lk_dmem = e_dmem; lk_addr = e_addr;
                lk_we = e_we; lk_be = e_be; lk_wdata = e_wdata;
            end else if (locked && e_grant) begin
                locked = 0;
            end
        end
    endtask

    task automatic runCycle(input stim_t st);
        @(negedge clk);
        applyStimulus(st);
        #1;
        modelStep();
    endtask

    function automatic stim_t idleStim();
        stim_t st;
        st          = '0;
        st.dmem_be  = 8'h0F;
        st.dmem_addr = 39'h2000;
        st.dmem_wdata = 64'h0123_4567_89AB_CDEF;
        return st;
    endfunction

    task automatic doReset();
        stim_t st;
        st = idleStim();
        st.rst = 1;
        runCycle(st);
        checkOutput("reset_busy", busy, 1'b0);
        runCycle(st);
    endtask

    initial begin
        s = idleStim();
        s.rst = 1;
        applyStimulus(s);
        starve = 0;
        locked = 0;

        // Simultaneous requests: dmem first, imem the following cycle.
        doReset();
        s = idleStim(); s.imem_req = 1; s.imem_addr = 39'h1000; s.dmem_req = 1; s.gnt = 1;
        runCycle(s);
        checkOutput("r030_dmem_first", dmem_gnt, 1'b1);
        checkOutput("r030_addr", mem_addr, 39'h2000);
        s.dmem_req = 0;
        runCycle(s);
        checkOutput("r030_imem_next", imem_gnt, 1'b1);

        // Locked imem request keeps the bus until granted.
        doReset();
        s = idleStim(); s.imem_req = 1; s.imem_addr = 39'h1000;
        runCycle(s);
        s.dmem_req = 1;
        for (int i = 0; i < 2; i++) begin
            runCycle(s);
            checkOutput($sformatf("r031_hold%0d", i), mem_addr, 39'h1000);
        end
        s.gnt = 1;
        runCycle(s);
        checkOutput("r031_imem_gnt", imem_gnt, 1'b1);
        s.imem_req = 0;
        runCycle(s);
        checkOutput("r031_dmem_gnt", dmem_gnt, 1'b1);

        // Starvation: imem wins on the fifth cycle.
        doReset();
        s = idleStim(); s.imem_req = 1; s.imem_addr = 39'h1000; s.dmem_req = 1; s.gnt = 1;
        for (int i = 0; i < 5; i++) begin
            s.rvalid = (i > 0);
            runCycle(s);
            checkOutput($sformatf("r032_imem_c%0d", i), imem_gnt, i == 4);
        end

        // FIFO full backpressure and response routing.
        doReset();
        s = idleStim(); s.imem_req = 1; s.imem_addr = 39'h1004; s.gnt = 1;
        runCycle(s);
        s.imem_req = 0; s.dmem_req = 1;
        runCycle(s);
        runCycle(s);
        checkOutput("r033_full_noreq", mem_req, 1'b0);
        s.dmem_req = 0; s.rvalid = 1; s.rdata = 64'hAABBCCDD_11223344;
        runCycle(s);
        checkOutput("r033_irv", imem_rvalid, 1'b1);
        checkOutput("r033_irdata", imem_rdata, 32'hAABBCCDD);
        runCycle(s);
        checkOutput("r033_drv", dmem_rvalid, 1'b1);

        // Push and pop together while full.
        doReset();
        s = idleStim(); s.imem_req = 1; s.imem_addr = 39'h1000; s.gnt = 1;
        runCycle(s);
        s.imem_req = 0; s.dmem_req = 1;
        runCycle(s);
        s.dmem_req = 0; s.imem_req = 1; s.imem_addr = 39'h1004; s.rvalid = 1; s.rdata = 64'h5555_6666_7777_8888;
        runCycle(s);
        checkOutput("r034_req", mem_req, 1'b1);
        checkOutput("r034_irv", imem_rvalid, 1'b1);
        checkOutput("r034_irdata", imem_rdata, 32'h7777_8888);
        s.imem_req = 0;
        runCycle(s);
        checkOutput("r034_drv", dmem_rvalid, 1'b1);
        runCycle(s);
        checkOutput("r034_irdata_hi", imem_rdata, 32'h5555_6666);
        runCycle(s);
        checkOutput("r034_empty_busy", busy, 1'b0);

        // Reset with two outstanding, then a stray response.
        doReset();
        s = idleStim(); s.imem_req = 1; s.dmem_req = 1; s.gnt = 1;
        runCycle(s);
        runCycle(s);
        s = idleStim(); s.rst = 1;
        runCycle(s);
        s.rst = 0; s.rvalid = 1;
        runCycle(s);
        checkOutput("r035_irv", imem_rvalid, 1'b0);
        checkOutput("r035_drv", dmem_rvalid, 1'b0);
        checkOutput("r035_busy", busy, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rst        = ($urandom_range(0, 99) == 0);
            s.imem_req   = ($urandom_range(0, 9) < 6);
            s.imem_addr  = VADDR'({$urandom, $urandom});
            s.dmem_req   = ($urandom_range(0, 9) < 6);
            s.dmem_we    = $urandom_range(0, 1);
            s.dmem_be    = 8'($urandom);
            s.dmem_addr  = VADDR'({$urandom, $urandom});
            s.dmem_wdata = {$urandom, $urandom};
            s.gnt        = ($urandom_range(0, 9) < 5);
            s.rvalid     = ($urandom_range(0, 9) < 4);
            s.rdata      = {$urandom, $urandom};
            runCycle(s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/obi_mem_arbiter.md
OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter

Interface
REQ-001 Parameter VADDR, default 39: address width of all ports.
REQ-002 Parameter MAX_OUTST, default 2: maximum outstanding granted transactions awaiting rvalid (1..4).
REQ-003 Parameter STARVE_LIM, default 4: consecutive dmem grants with imem waiting before imem gets priority.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 imem_req_i / imem_addr_i / imem_gnt_o  in/in/out  1/VADDR/1  fetch OBI read-request channel.
REQ-007 imem_rvalid_o / imem_rdata_o  out/out  1/32  fetch response channel.
REQ-008 dmem_req_i / dmem_we_i / dmem_be_i / dmem_addr_i / dmem_wdata_i  in  1/1/8/VADDR/64  data OBI request channel.
REQ-009 dmem_gnt_o / dmem_rvalid_o / dmem_rdata_o  out  1/1/64  data grant and response.
REQ-010 mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  out  1/1/8/VADDR/64  shared device request channel.
REQ-011 mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1/1/64  shared device grant and response.
REQ-012 busy_o  out  1  high while any transaction is outstanding or the request channel is locked.

Function
REQ-013 Arbitration FSM SHALL have states IDLE and LOCKED; LOCKED holds the owner of an asserted-but-ungranted mem_req_o.
REQ-014 In IDLE, owner SHALL be dmem if dmem_req_i and (not imem_req_i or starve count < STARVE_LIM), else imem if imem_req_i.
REQ-015 Request outputs SHALL combinationally mux the selected owner's fields; imem requests drive we=0, be=8'hFF, wdata=0.
REQ-016 mem_req_o SHALL be low when the outstanding FIFO is full, unless an entry pops in the same cycle.
REQ-017 IDLE->LOCKED when mem_req_o=1 and mem_gnt_i=0; LOCKED->IDLE on mem_gnt_i=1; owner and all request fields frozen while LOCKED.
REQ-018 Owner's gnt_o SHALL equal mem_gnt_i gated by mem_req_o; the non-owner's gnt_o SHALL be 0.
REQ-019 Each grant SHALL push {owner, addr[2]} into an in-order FIFO of depth MAX_OUTST; each mem_rvalid_i SHALL pop the head entry.
REQ-020 mem_rvalid_i SHALL route to the head owner's rvalid_o in the same cycle (zero latency); the other rvalid_o stays 0.
REQ-021 imem_rdata_o SHALL be mem_rdata_i[63:32] if head addr[2]=1, else [31:0]; dmem_rdata_o = mem_rdata_i.
REQ-022 Simultaneous push and pop SHALL be legal at any occupancy, including full; count unchanged.
REQ-023 mem_rvalid_i with empty FIFO SHALL be ignored (no rvalid_o, no state change).
REQ-024 Starve counter SHALL increment on a dmem grant while imem_req_i=1, clear on any imem grant, and saturate at STARVE_LIM.
REQ-025 FIFO pointers SHALL wrap modulo MAX_OUTST; count width is clog2(MAX_OUTST+1).

Reset
REQ-026 While rst_i=1: state IDLE, FIFO empty, starve count 0, all gnt/rvalid/mem_req_o outputs 0, busy_o 0.
REQ-027 Reset asserted mid-transaction SHALL discard outstanding entries; late mem_rvalid_i after release SHALL be dropped per REQ-023.

Structure
REQ-028 Owner encoding (IMEM=0, DMEM=1) and FSM state encoding SHALL live in the shared Lucid64 package header.
REQ-029 The outstanding-response FIFO SHALL be a sub-module named obi_resp_fifo, parameterised on depth and entry width.

Verification
REQ-030 Both requesters assert in the same cycle, gnt=1 -> dmem granted, dmem_addr on mem_addr_o; imem granted next cycle.
REQ-031 imem req addr 0x1000 held, gnt low 3 cycles, dmem asserts in cycle 2 -> mem_addr_o stays 0x1000 until gnt, then dmem served.
REQ-032 Continuous dmem plus imem pending, gnt always 1 -> imem granted on exactly the 5th cycle (STARVE_LIM=4).
REQ-033 Two grants (imem addr 0x1004, dmem), no rvalid -> mem_req_o low on third request; rvalid with rdata 0xAABBCCDD_11223344 -> imem_rdata_o=0xAABBCCDD, then dmem_rvalid_o.
REQ-034 FIFO full, rvalid and gnt in same cycle -> push accepted, count stays 2, in-order routing preserved.
REQ-035 rst_i pulsed with 2 outstanding, then stray mem_rvalid_i -> no rvalid_o, busy_o=0.
